// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared state encoding and tag constants for the SYS_CTRL response path
package sys_ctrl_pkg;

  // Response sequencer states; WR_TAG is only entered when tagging is built in
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_TAG = 2'd1,
    WR_B0  = 2'd2,
    WR_B1  = 2'd3
  } tx_state_t;

  // Tag bytes that identify the response source on the UART link
  localparam logic [7:0] TAG_ALU = 8'hA5;
  localparam logic [7:0] TAG_RD  = 8'h5A;

endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// rtl/sys_ctrl_tx_seq.sv - splits ALU/regfile results into bytes for the TX FIFO (optional tag: SYS_CTRL_TX_TAG_EN)
module sys_ctrl_tx_seq
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      alu_valid,
  input  logic [2*DATA_WIDTH-1:0]   alu_result,
  input  logic                      rd_valid,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      fifo_full,
  output logic [DATA_WIDTH-1:0]     fifo_wr_data,
  output logic                      fifo_wr_inc,
  output logic                      busy,
  output logic                      drop_err
);

`ifdef SYS_CTRL_TX_TAG_EN
  // Tags are defined as bytes; fit them to the configured word width
  localparam logic [DATA_WIDTH-1:0] TAG_ALU_W = DATA_WIDTH'(TAG_ALU);
  localparam logic [DATA_WIDTH-1:0] TAG_RD_W  = DATA_WIDTH'(TAG_RD);
  localparam tx_state_t FIRST_WR = WR_TAG;
`else
  localparam tx_state_t FIRST_WR = WR_B0;
`endif

  tx_state_t                   state_q, state_d;
  logic [2*DATA_WIDTH-1:0]     cap_q, cap_d;
  logic                        is_alu_q, is_alu_d;
  logic [DATA_WIDTH-1:0]       wr_data_q, wr_data_d;
  logic                        wr_inc_q, wr_inc_d;
  logic                        drop_q, drop_d;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, capture and FIFO write decode; a full FIFO simply holds the current write state
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    is_alu_d  = is_alu_q;
    wr_data_d = wr_data_q;
    wr_inc_d  = 1'b0;
    drop_d    = drop_q;

    case (state_q)
      IDLE: begin
        if (alu_valid) begin
          cap_d    = alu_result;
          is_alu_d = 1'b1;
          state_d  = FIRST_WR;
          // ALU has priority; a simultaneous regfile read is lost
          if (rd_valid) begin
            drop_d = 1'b1;
          end
        end else if (rd_valid) begin
          cap_d    = {{DATA_WIDTH{1'b0}}, rd_data};
          is_alu_d = 1'b0;
          state_d  = FIRST_WR;
        end
      end
`ifdef SYS_CTRL_TX_TAG_EN
      WR_TAG: begin
        if (!fifo_full) begin
          wr_inc_d  = 1'b1;
          wr_data_d = is_alu_q ? TAG_ALU_W : TAG_RD_W;
          state_d   = WR_B0;
        end
      end
`endif
      WR_B0: begin
        if (!fifo_full) begin
          wr_inc_d  = 1'b1;
          wr_data_d = cap_q[DATA_WIDTH-1:0];
          state_d   = is_alu_q ? WR_B1 : IDLE;
        end
      end
      WR_B1: begin
        if (!fifo_full) begin
          wr_inc_d  = 1'b1;
          wr_data_d = cap_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // No queueing: any result arriving while a response is in flight is lost
    if ((state_q != IDLE) && (alu_valid || rd_valid)) begin
      drop_d = 1'b1;
    end
  end

  // Capture, registered FIFO write port and sticky drop flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cap_q     <= '0;
      is_alu_q  <= 1'b0;
      wr_data_q <= '0;
      wr_inc_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      cap_q     <= cap_d;
      is_alu_q  <= is_alu_d;
      wr_data_q <= wr_data_d;
      wr_inc_q  <= wr_inc_d;
      drop_q    <= drop_d;
    end
  end

  assign fifo_wr_data = wr_data_q;
  assign fifo_wr_inc  = wr_inc_q;
  assign busy         = (state_q != IDLE);
  assign drop_err     = drop_q;

endmodule
